// File: rtl/axi_tester_pkg.sv
// Shared state encoding, AXI constants and the test pattern for the AXI memory tester.
package axi_tester_pkg;

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StWa   = 3'd1;
   localparam logic [2:0] StWd   = 3'd2;
   localparam logic [2:0] StWb   = 3'd3;
   localparam logic [2:0] StRa   = 3'd4;
   localparam logic [2:0] StRd   = 3'd5;
   localparam logic [2:0] StDone = 3'd6;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed);
      return addr ^ seed;
   endfunction

endpackage

// File: rtl/axi_tester_chk.sv
// Read-beat comparator with saturating error counter and first-error address latch.
module axi_tester_chk
   import axi_tester_pkg::*;
#(
   parameter logic [3:0] AXI_ID = 4'h1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        beat_i,
   input  logic [31:0] exp_data_i,
   input  logic        exp_last_i,
   input  logic [31:0] beat_addr_i,
   input  logic [31:0] rdata_i,
   input  logic [3:0]  rid_i,
   input  logic [1:0]  rresp_i,
   input  logic        rlast_i,
   input  logic        wr_err_i,
   input  logic [31:0] wr_addr_i,
   output logic [15:0] err_count_o,
   output logic [31:0] first_err_o
);

   logic [15:0] err_count_q, err_count_d;
   logic [31:0] first_err_q, first_err_d;
   logic        rd_err, inc;
   logic [31:0] err_addr;

   // All read-beat faults fold into a single increment.
   assign rd_err = beat_i && ((rdata_i != exp_data_i) || (rresp_i != AXI_RESP_OKAY) ||
                              (rid_i != AXI_ID) || (rlast_i != exp_last_i));
   assign inc      = rd_err || wr_err_i;
   assign err_addr = wr_err_i ? wr_addr_i : beat_addr_i;

   always_comb begin
      err_count_d = err_count_q;
      first_err_d = first_err_q;
      if (clr_i) begin
         err_count_d = '0;
         first_err_d = '0;
      end else if (inc) begin
         if (err_count_q == 16'h0000) first_err_d = err_addr;
         if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_count_q <= '0;
         first_err_q <= '0;
      end else begin
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
      end
   end

   assign err_count_o = err_count_q;
   assign first_err_o = first_err_q;

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 initiator: writes an address-derived pattern in INCR bursts, reads it back and checks it.
module axi_mem_tester
   import axi_tester_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned NUM_BURSTS = 1024,
   parameter logic [31:0] SEED       = 32'hA5C3_5A3C,
   parameter logic [3:0]  AXI_ID     = 4'h1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        start,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] awaddr,
   output logic [3:0]  awid,
   output logic [7:0]  awlength,
   output logic [1:0]  awburst,
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   input  logic        bvalid,
   output logic        bready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   output logic        arvalid,
   input  logic        arready,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [7:0]  arlength,
   output logic [1:0]  arburst,
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [3:0]  rid,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [31:0] first_err,
   output logic [7:0]  led
);

   localparam int unsigned   BCW        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam logic [7:0]    LAST_BEAT  = 8'(BURST_LEN - 1);
   localparam logic [BCW-1:0] LAST_BURST = BCW'(NUM_BURSTS - 1);

   logic [2:0]     state_q, state_d;
   logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
   logic [7:0]     beat_cnt_q, beat_cnt_d;
   logic           clr, last_beat, last_burst, wr_err;
   logic [31:0]    burst_addr, beat_addr;
   logic [3:0]     burst_led;

   assign burst_addr = BASE_ADDR + 32'(burst_cnt_q) * (BURST_LEN * 4);
   assign beat_addr  = burst_addr + {22'b0, beat_cnt_q, 2'b00};
   assign last_beat  = (beat_cnt_q == LAST_BEAT);
   assign last_burst = (burst_cnt_q == LAST_BURST);

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      clr         = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StWa;
               burst_cnt_d = '0;
               beat_cnt_d  = '0;
               clr         = 1'b1;
            end
         end
         StWa: if (awready) state_d = StWd;
         StWd: begin
            if (wready) begin
               if (last_beat) begin
                  state_d    = StWb;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         StWb: begin
            if (bvalid) begin
               state_d     = last_burst ? StRa : StWa;
               burst_cnt_d = last_burst ? '0 : burst_cnt_q + BCW'(1);
            end
         end
         StRa: if (arready) state_d = StRd;
         StRd: begin
            if (rvalid) begin
               // Either an rlast or the final expected beat closes the burst.
               if (rlast || last_beat) begin
                  state_d     = last_burst ? StDone : StRa;
                  burst_cnt_d = last_burst ? '0 : burst_cnt_q + BCW'(1);
                  beat_cnt_d  = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= StIdle;
         burst_cnt_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign awvalid  = (state_q == StWa);
   assign awaddr   = burst_addr;
   assign awid     = AXI_ID;
   assign awlength = LAST_BEAT;
   assign awburst  = AXI_BURST_INCR;
   assign wvalid   = (state_q == StWd);
   assign wdata    = pat(beat_addr, SEED);
   assign wstrb    = 4'hF;
   assign wlast    = last_beat;
   assign bready   = (state_q == StWb);
   assign arvalid  = (state_q == StRa);
   assign araddr   = burst_addr;
   assign arid     = AXI_ID;
   assign arlength = LAST_BEAT;
   assign arburst  = AXI_BURST_INCR;
   assign rready   = (state_q == StRd);

   assign wr_err = bvalid && bready && ((bresp != AXI_RESP_OKAY) || (bid != AXI_ID));

   axi_tester_chk #(
      .AXI_ID(AXI_ID)
   ) u_chk (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .clr_i      (clr),
      .beat_i     (rvalid && rready),
      .exp_data_i (wdata),
      .exp_last_i (last_beat),
      .beat_addr_i(beat_addr),
      .rdata_i    (rdata),
      .rid_i      (rid),
      .rresp_i    (rresp),
      .rlast_i    (rlast),
      .wr_err_i   (wr_err),
      .wr_addr_i  (burst_addr),
      .err_count_o(err_count),
      .first_err_o(first_err)
   );

   assign busy = (state_q != StIdle) && (state_q != StDone);
   assign done = (state_q == StDone);
   assign pass = done && (err_count == 16'h0000);

   if (BCW >= 4) begin : g_led_wide
      assign burst_led = burst_cnt_q[3:0];
   end else begin : g_led_narrow
      assign burst_led = 4'(burst_cnt_q);
   end

   assign led = {busy, done, pass, (err_count != 16'h0000), burst_led};

endmodule

// File: tb/tb_axi_mem_tester.sv
// Scoreboard bench for axi_mem_tester against a configurable single-outstanding AXI slave.
module tb_axi_mem_tester;

   localparam int unsigned BL   = 4;
   localparam int unsigned NB   = 2;
   localparam logic [31:0] SEED = 32'hA5C3_5A3C;

   logic        CLK, RST_N, start;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] awaddr, wdata, araddr, rdata, first_err;
   logic [3:0]  awid, wstrb, bid, arid, rid;
   logic [7:0]  awlength, arlength, led;
   logic [1:0]  awburst, bresp, arburst, rresp;
   logic        busy, done, pass;
   logic [15:0] err_count;

   axi_mem_tester #(
      .BASE_ADDR (32'h0),
      .BURST_LEN (BL),
      .NUM_BURSTS(NB),
      .SEED      (SEED),
      .AXI_ID    (4'h1)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
      .awlength(awlength), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlength(arlength), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp),
      .rlast(rlast),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_err(first_err), .led(led)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } wbeat_t;

   logic [31:0] aw_q[$];
   logic [31:0] ar_q[$];
   wbeat_t      w_q[$];

   bit stall_en = 0;
   bit corrupt_en = 0;
   int bresp_err_burst = -1;
   int early_burst = -1;
   int w_beats = 0;
   int r_beats = 0;

   logic [31:0] mem [0:7];

   // Slave + protocol monitor: sample handshakes at negedge, respond just after posedge.
   initial begin
      bit aw_f = 0, w_f = 0, b_f = 0, ar_f = 0, r_f = 0, w_l = 0, r_l = 0;
      bit prev_aw = 0, prev_w = 0, prev_ar = 0, w_allowed = 0, b_pend = 0, r_active = 0;
      logic [31:0] aw_a = 0, w_d = 0, ar_a = 0, p_awaddr = 0, p_wdata = 0, p_araddr = 0;
      logic [31:0] wr_addr = 0, rd_addr = 0;
      int rd_beat = 0, wr_burst = 0, rd_burst = 0;
      wbeat_t wb;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bid = 4'h1; bresp = 2'b00; rid = 4'h1; rresp = 2'b00; rlast = 0; rdata = 0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            {aw_f, w_f, b_f, ar_f, r_f} = '0;
            {prev_aw, prev_w, prev_ar, w_allowed} = '0;
         end else begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            if (prev_aw) begin
               check_val("aw_hold_valid", awvalid, 1);
               check_val("aw_hold_addr", awaddr, p_awaddr);
            end
            if (prev_w) begin
               check_val("w_hold_valid", wvalid, 1);
               check_val("w_hold_data", wdata, p_wdata);
            end
            if (prev_ar) begin
               check_val("ar_hold_valid", arvalid, 1);
               check_val("ar_hold_addr", araddr, p_araddr);
            end
            if (wvalid) check_val("w_after_aw", w_allowed, 1);
            if (aw_f) begin
               check_val("aw_expected", aw_q.size() != 0, 1);
               if (aw_q.size() != 0) check_val("awaddr", awaddr, aw_q.pop_front());
               check_val("awlength", awlength, BL - 1);
               check_val("awburst", awburst, 2'b01);
               check_val("awid", awid, 4'h1);
               w_allowed = 1;
            end
            if (w_f) begin
               check_val("w_expected", w_q.size() != 0, 1);
               if (w_q.size() != 0) begin
                  wb = w_q.pop_front();
                  check_val("wdata", wdata, wb.data);
                  check_val("wlast", wlast, wb.last);
               end
               check_val("wstrb", wstrb, 4'hF);
               if (wlast) w_allowed = 0;
               w_beats++;
            end
            if (ar_f) begin
               check_val("ar_expected", ar_q.size() != 0, 1);
               if (ar_q.size() != 0) check_val("araddr", araddr, ar_q.pop_front());
               check_val("arlength", arlength, BL - 1);
               check_val("arburst", arburst, 2'b01);
               check_val("arid", arid, 4'h1);
            end
            if (r_f) r_beats++;
            prev_aw = awvalid && !awready; p_awaddr = awaddr;
            prev_w  = wvalid && !wready;   p_wdata  = wdata;
            prev_ar = arvalid && !arready; p_araddr = araddr;
            aw_a = awaddr; w_d = wdata; w_l = wlast; ar_a = araddr; r_l = rlast;
         end
         @(posedge CLK);
         #1;
         if (!RST_N) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; rlast = 0;
            b_pend = 0; r_active = 0;
         end else begin
            if (aw_f) begin wr_addr = aw_a; wr_burst = int'(aw_a / 16); end
            if (w_f) begin
               mem[wr_addr[4:2]] = w_d;
               wr_addr += 4;
               if (w_l) b_pend = 1;
            end
            if (b_f) b_pend = 0;
            if (ar_f) begin
               rd_addr = ar_a; rd_beat = 0; r_active = 1; rd_burst = int'(ar_a / 16);
            end
            if (r_f) begin
               if (r_l) r_active = 0;
               else begin rd_addr += 4; rd_beat++; end
            end
            awready = !stall_en || ($urandom_range(1) != 0);
            wready  = !stall_en || ($urandom_range(1) != 0);
            arready = !stall_en || ($urandom_range(1) != 0);
            bvalid  = b_pend;
            bresp   = (wr_burst == bresp_err_burst) ? 2'b10 : 2'b00;
            if (!(rvalid && !r_f)) rvalid = r_active && (!stall_en || ($urandom_range(1) != 0));
            if (rvalid) begin
               rdata = mem[rd_addr[4:2]] ^ ((corrupt_en && rd_addr == 32'h14) ? 32'h1 : 32'h0);
               rlast = (rd_beat == BL - 1) || (rd_burst == early_burst && rd_beat == 1);
            end
         end
      end
   end

   task automatic load_sb();
      aw_q.delete(); ar_q.delete(); w_q.delete();
      for (int b = 0; b < NB; b++) begin
         aw_q.push_back(32'(b * BL * 4));
         ar_q.push_back(32'(b * BL * 4));
         for (int k = 0; k < BL; k++)
            w_q.push_back({32'(b * BL * 4 + k * 4) ^ SEED, k == BL - 1});
      end
      w_beats = 0;
      r_beats = 0;
   endtask

   task automatic pulse_start();
      @(posedge CLK); #1 start = 1;
      @(posedge CLK); #1 start = 0;
   endtask

   task automatic run_pass(input string tag, input int exp_err, input logic [31:0] exp_first,
                           input int exp_rbeats);
      int cyc = 0;
      load_sb();
      pulse_start();
      check_val({tag, "_busy"}, busy, 1);
      check_val({tag, "_clr_err"}, err_count, 0);
      check_val({tag, "_clr_first"}, first_err, 0);
      while (!done && cyc < 3000) begin
         @(posedge CLK); #1;
         cyc++;
      end
      check_val({tag, "_done"}, done, 1);
      check_val({tag, "_pass"}, pass, exp_err == 0);
      check_val({tag, "_err_count"}, err_count, exp_err);
      check_val({tag, "_first_err"}, first_err, exp_first);
      check_val({tag, "_w_beats"}, w_beats, NB * BL);
      check_val({tag, "_r_beats"}, r_beats, exp_rbeats);
      check_val({tag, "_sb_left"}, aw_q.size() + ar_q.size() + w_q.size(), 0);
      check_val({tag, "_led_hi"}, led[7:4], {2'b01, exp_err == 0, exp_err != 0});
   endtask

   initial begin
      int cyc;
      RST_N = 0;
      start = 0;
      #1;
      check_val("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check_val("rst_flags", {busy, done, pass}, 0);
      check_val("rst_err_count", err_count, 0);
      check_val("rst_first_err", first_err, 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK); RST_N = 1;

      run_pass("ideal", 0, 32'h0, NB * BL);

      corrupt_en = 1;
      run_pass("corrupt", 1, 32'h14, NB * BL);
      corrupt_en = 0;
      run_pass("restart", 0, 32'h0, NB * BL);

      stall_en = 1;
      run_pass("stall", 0, 32'h0, NB * BL);
      stall_en = 0;

      bresp_err_burst = 1;
      run_pass("bresp", 1, 32'h10, NB * BL);
      bresp_err_burst = -1;

      early_burst = 0;
      run_pass("early_rlast", 1, 32'h4, BL + 2);
      early_burst = -1;

      // Reset while the third write beat is presented.
      load_sb();
      pulse_start();
      cyc = 0;
      while (w_beats < 2 && cyc < 500) begin
         @(posedge CLK); #2;
         cyc++;
      end
      check_val("mid_wd_reached", w_beats, 2);
      check_val("mid_wd_wvalid", wvalid, 1);
      @(negedge CLK); #2 RST_N = 0;
      #1;
      check_val("mid_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
      check_val("mid_rst_flags", {busy, done, pass}, 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK); RST_N = 1;
      run_pass("after_rst", 0, 32'h0, NB * BL);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
